// File: rtl/burst_fifo_filler_if.sv
// burst_fifo_filler_if: control, DDR read-port and queue-producer signals of the burst filler
// Ports: none; master modport is the filler side, slave modport is the environment side
// (control source, DDR arbiter and elastic queue).
interface burst_fifo_filler_if;
    logic        io_start;
    logic [31:0] io_addr;
    logic [15:0] io_words;
    logic        io_abort;
    logic        io_busy;
    logic        io_done;
    logic        io_ddr_rd;
    logic [31:0] io_ddr_addr;
    logic [7:0]  io_ddr_burstLength;
    logic        io_ddr_waitReq;
    logic        io_ddr_valid;
    logic [63:0] io_ddr_dout;
    logic        io_enq_valid;
    logic [63:0] io_enq_bits;
    logic [6:0]  io_count;
    logic        io_flush;

    modport master (
        input  io_start, io_addr, io_words, io_abort,
        input  io_ddr_waitReq, io_ddr_valid, io_ddr_dout, io_count,
        output io_busy, io_done, io_ddr_rd, io_ddr_addr, io_ddr_burstLength,
        output io_enq_valid, io_enq_bits, io_flush
    );

    modport slave (
        output io_start, io_addr, io_words, io_abort,
        output io_ddr_waitReq, io_ddr_valid, io_ddr_dout, io_count,
        input  io_busy, io_done, io_ddr_rd, io_ddr_addr, io_ddr_burstLength,
        input  io_enq_valid, io_enq_bits, io_flush
    );
endinterface

// File: rtl/burst_fifo_filler.sv
// burst_fifo_filler: DDR burst read engine that fills a 64-bit elastic queue under a credit check
// Ports: clock; reset (async, active-high); bus (master modport) carrying start/addr/words/abort,
// busy/done, the DDR read request and beat return, and the queue enq/flush/count signals.
module burst_fifo_filler #(
    parameter int BURST_LEN = 16,
    parameter int DEPTH = 64
) (
    input logic clock,
    input logic reset,
    burst_fifo_filler_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state;
    logic [31:0] addr_q;
    logic [15:0] remaining;
    logic [6:0] inflight;
    logic [6:0] inflight_next;
    logic [7:0] len;
    logic [63:0] enq_bits_q;
    logic aborting;
    logic done_q;
    logic flush_q;
    logic enq_valid_q;
    logic credit;
    logic rd;
    logic accept;
    logic abort_now;
    logic discard;
    logic enq_next;
    logic drain_done;

    assign len = (remaining < 16'(BURST_LEN)) ? remaining[7:0] : 8'(BURST_LEN);
    // count+inflight only shrinks while a request waits, so rd never drops under waitReq
    assign credit = ({1'b0, bus.io_count} + {1'b0, inflight} + len) <= 8'(DEPTH);
    assign rd = state == REQ && credit && !bus.io_abort;
    assign accept = rd && !bus.io_ddr_waitReq;
    assign abort_now = bus.io_abort && state != IDLE;
    // once aborted, returning beats are only counted off, never enqueued
    assign discard = aborting || abort_now;
    assign enq_next = bus.io_ddr_valid && !discard;
    assign inflight_next = inflight + (accept ? len[6:0] : 7'd0) - 7'(enq_valid_q)
                         - 7'(bus.io_ddr_valid && discard);
    // looks one edge ahead so done lands the cycle right after the last enqueue
    assign drain_done = state == DRAIN && inflight_next == 7'd0 && !enq_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr_q <= '0;
            remaining <= '0;
            inflight <= '0;
            enq_bits_q <= '0;
            aborting <= 1'b0;
            done_q <= 1'b0;
            flush_q <= 1'b0;
            enq_valid_q <= 1'b0;
        end else begin
            enq_valid_q <= enq_next;
            if (bus.io_ddr_valid) enq_bits_q <= bus.io_ddr_dout;
            inflight <= inflight_next;
            flush_q <= abort_now;
            done_q <= drain_done;
            case (state)
                IDLE: if (bus.io_start) begin
                    addr_q <= bus.io_addr;
                    remaining <= bus.io_words;
                    state <= (bus.io_words == 16'd0) ? DRAIN : REQ;
                end
                REQ: if (abort_now) begin
                    remaining <= '0;
                    aborting <= 1'b1;
                    state <= DRAIN;
                end else if (accept) begin
                    addr_q <= addr_q + {21'd0, len, 3'd0};
                    remaining <= remaining - {8'd0, len};
                    if (remaining == {8'd0, len}) state <= DRAIN;
                end
                DRAIN: begin
                    if (abort_now) aborting <= 1'b1;
                    if (drain_done) begin
                        aborting <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.io_busy = state != IDLE;
    assign bus.io_done = done_q;
    assign bus.io_ddr_rd = rd;
    assign bus.io_ddr_addr = addr_q;
    assign bus.io_ddr_burstLength = len;
    assign bus.io_enq_valid = enq_valid_q;
    assign bus.io_enq_bits = enq_bits_q;
    assign bus.io_flush = flush_q;
endmodule
